// File: rtl/pipe_generator_if.sv
// Pipe stream bundle: game controls in, three pipe positions and run status out.
// master = pipe generator, slave = the side issuing controls and consuming pipes.
interface pipe_generator_if #(
  parameter int N = 10
);
  logic         tick;
  logic         start;
  logic         game_over;
  logic [N-1:0] pipe1_x, pipe1_y0, pipe1_y1;
  logic [N-1:0] pipe2_x, pipe2_y0, pipe2_y1;
  logic [N-1:0] pipe3_x, pipe3_y0, pipe3_y1;
  logic         running;

  modport master (
    input  tick, start, game_over,
    output pipe1_x, pipe1_y0, pipe1_y1,
    output pipe2_x, pipe2_y0, pipe2_y1,
    output pipe3_x, pipe3_y0, pipe3_y1,
    output running
  );

  modport slave (
    output tick, start, game_over,
    input  pipe1_x, pipe1_y0, pipe1_y1,
    input  pipe2_x, pipe2_y0, pipe2_y1,
    input  pipe3_x, pipe3_y0, pipe3_y1,
    input  running
  );
endinterface

// File: rtl/pipe_generator.sv
// Three-pipe scroller: moves pipes left one unit per tick in RUN, recycles a pipe
// leaving x=0 to the back with an LFSR-derived gap, freezes on game_over.
module pipe_generator #(
  parameter int          N       = 10,
  parameter int          START_X = 400,
  parameter int          SPACING = 200,
  parameter int          GAP     = 120,
  parameter int          Y_MIN   = 40,
  parameter int          Y1_MAX  = 320,
  parameter int          INIT_Y1 = 180,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  pipe_generator_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [N-1:0] RESPAWN_X = N'(3 * SPACING - 1);
  localparam logic [N-1:0] INIT_Y1_N = N'(INIT_Y1);
  localparam logic [N-1:0] INIT_Y0_N = N'(INIT_Y1 + GAP);

  state_t       state, state_nxt;
  logic         scroll, reload;
  logic         running_q;
  logic [15:0]  lfsr;
  logic [N-1:0] x_q  [3];
  logic [N-1:0] y0_q [3];
  logic [N-1:0] y1_q [3];
  logic [N-1:0] y1_new, y0_new;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Widened by one bit so the clamp compares the true sum, not a wrapped one.
  function automatic logic [N-1:0] gap_bottom(input logic [7:0] r);
    logic [N:0] sum;
    sum = (N+1)'(Y_MIN) + (N+1)'(r);
    if (sum > (N+1)'(Y1_MAX)) return N'(Y1_MAX);
    return sum[N-1:0];
  endfunction

  function automatic logic [N-1:0] gap_top(input logic [N-1:0] y1);
    logic [N:0] sum;
    sum = {1'b0, y1} + (N+1)'(GAP);
    return sum[N-1:0];
  endfunction

  assign y1_new = gap_bottom(lfsr[7:0]);
  assign y0_new = gap_top(y1_new);

  always_comb begin
    state_nxt = state;
    scroll    = 1'b0;
    reload    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.game_over)  state_nxt = OVER;
        else if (bus.tick)  scroll    = 1'b1;
      end
      OVER: begin
        if (bus.start) begin
          state_nxt = RUN;
          reload    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      running_q <= 1'b0;
      lfsr      <= SEED;
      for (int k = 0; k < 3; k++) begin
        x_q[k]  <= N'(START_X + k * SPACING);
        y1_q[k] <= INIT_Y1_N;
        y0_q[k] <= INIT_Y0_N;
      end
    end else begin
      state     <= state_nxt;
      running_q <= (state_nxt == RUN);
      lfsr      <= lfsr_next(lfsr);
      if (reload) begin
        for (int k = 0; k < 3; k++) begin
          x_q[k]  <= N'(START_X + k * SPACING);
          y1_q[k] <= INIT_Y1_N;
          y0_q[k] <= INIT_Y0_N;
        end
      end else if (scroll) begin
        // Spacing guarantees at most one pipe sits at x=0, so one shared y1_new suffices.
        for (int k = 0; k < 3; k++) begin
          if (x_q[k] != '0) begin
            x_q[k] <= x_q[k] - N'(1);
          end else begin
            x_q[k]  <= RESPAWN_X;
            y1_q[k] <= y1_new;
            y0_q[k] <= y0_new;
          end
        end
      end
    end
  end

  assign bus.pipe1_x  = x_q[0];
  assign bus.pipe1_y0 = y0_q[0];
  assign bus.pipe1_y1 = y1_q[0];
  assign bus.pipe2_x  = x_q[1];
  assign bus.pipe2_y0 = y0_q[1];
  assign bus.pipe2_y1 = y1_q[1];
  assign bus.pipe3_x  = x_q[2];
  assign bus.pipe3_y0 = y0_q[2];
  assign bus.pipe3_y1 = y1_q[2];
  assign bus.running  = running_q;

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator: vector table for FSM/hold behaviour, then
// hand-written recycle, restart, long scroll and mid-run reset sequences.
module tb_pipe_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pipe_generator_if #(.N(10)) bus();

  pipe_generator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Independent 16-bit Fibonacci LFSR (taps 16,14,13,11) tracking the DUT's free-running one.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    logic t, s, g;
    int   x1, x2, x3;
    logic run;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] lf_pre;
  int          m_x[3];
  int          m_y1[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addv(input logic t, s, g, input int x1, x2, x3, input logic run);
    vec_t v;
    v.t = t; v.s = s; v.g = g; v.x1 = x1; v.x2 = x2; v.x3 = x3; v.run = run;
    vecs.push_back(v);
  endtask

  task automatic step(input logic t, s, g);
    bus.tick = t; bus.start = s; bus.game_over = g;
    lf_pre = m_lfsr;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_y1(input logic [15:0] lf);
    int v;
    v = 40 + int'(lf[7:0]);
    return (v > 320) ? 320 : v;
  endfunction

  function automatic int ring(input int a, input int b);
    return ((b - a) % 600 + 600) % 600;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " p1x"}, int'(bus.pipe1_x), 400);
    chk({tag, " p2x"}, int'(bus.pipe2_x), 600);
    chk({tag, " p3x"}, int'(bus.pipe3_x), 800);
    chk({tag, " p1y1"}, int'(bus.pipe1_y1), 180);
    chk({tag, " p2y1"}, int'(bus.pipe2_y1), 180);
    chk({tag, " p3y1"}, int'(bus.pipe3_y1), 180);
    chk({tag, " p1y0"}, int'(bus.pipe1_y0), 300);
    chk({tag, " p2y0"}, int'(bus.pipe2_y0), 300);
    chk({tag, " p3y0"}, int'(bus.pipe3_y0), 300);
    chk({tag, " running"}, int'(bus.running), 0);
  endtask

  task automatic model_tick(input logic [15:0] lf);
    for (int k = 0; k < 3; k++) begin
      if (m_x[k] != 0) m_x[k] = m_x[k] - 1;
      else begin
        m_x[k]  = 599;
        m_y1[k] = exp_y1(lf);
      end
    end
  endtask

  task automatic check_model(input string tag);
    int xs[3], y1s[3], y0s[3];
    xs[0] = int'(bus.pipe1_x);  xs[1] = int'(bus.pipe2_x);  xs[2] = int'(bus.pipe3_x);
    y1s[0] = int'(bus.pipe1_y1); y1s[1] = int'(bus.pipe2_y1); y1s[2] = int'(bus.pipe3_y1);
    y0s[0] = int'(bus.pipe1_y0); y0s[1] = int'(bus.pipe2_y0); y0s[2] = int'(bus.pipe3_y0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s x[%0d]", tag, k), xs[k], m_x[k]);
      chk($sformatf("%s y1[%0d]", tag, k), y1s[k], m_y1[k]);
      chk($sformatf("%s gap[%0d]", tag, k), y0s[k] - y1s[k], 120);
      chk($sformatf("%s y1range[%0d]", tag, k), int'(y1s[k] >= 40 && y1s[k] <= 320), 1);
    end
    chk({tag, " spacing12"}, ring(xs[0], xs[1]), 200);
    chk({tag, " spacing23"}, ring(xs[1], xs[2]), 200);
    chk({tag, " running"}, int'(bus.running), 1);
  endtask

  initial begin
    int y_exp;
    bus.tick = 1'b0; bus.start = 1'b0; bus.game_over = 1'b0;

    // Asynchronous reset with no clock edge yet.
    #1 reset = 1'b0;
    #1 check_reset_values("async_reset");
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // IDLE holds on ticks; start enters RUN without a move; game_over wins over tick;
    // OVER ignores ticks; start in OVER reloads.
    repeat (5) addv(1, 0, 0, 400, 600, 800, 0);
    addv(1, 1, 0, 400, 600, 800, 1);
    addv(1, 0, 0, 399, 599, 799, 1);
    addv(1, 1, 0, 398, 598, 798, 1);
    addv(0, 0, 0, 398, 598, 798, 1);
    addv(1, 0, 1, 398, 598, 798, 0);
    repeat (10) addv(1, 0, 0, 398, 598, 798, 0);
    addv(1, 1, 0, 400, 600, 800, 1);
    addv(1, 0, 0, 399, 599, 799, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].t, vecs[i].s, vecs[i].g);
      chk($sformatf("vec%0d p1x", i), int'(bus.pipe1_x), vecs[i].x1);
      chk($sformatf("vec%0d p2x", i), int'(bus.pipe2_x), vecs[i].x2);
      chk($sformatf("vec%0d p3x", i), int'(bus.pipe3_x), vecs[i].x3);
      chk($sformatf("vec%0d run", i), int'(bus.running), int'(vecs[i].run));
      chk($sformatf("vec%0d p1y1", i), int'(bus.pipe1_y1), 180);
      chk($sformatf("vec%0d p1y0", i), int'(bus.pipe1_y0), 300);
    end

    // Scroll pipe1 down to x=0, then recycle it.
    repeat (399) step(1, 0, 0);
    chk("at_zero p1x", int'(bus.pipe1_x), 0);
    chk("at_zero p2x", int'(bus.pipe2_x), 200);
    chk("at_zero p3x", int'(bus.pipe3_x), 400);
    step(1, 0, 0);
    y_exp = exp_y1(lf_pre);
    chk("recycle p1x", int'(bus.pipe1_x), 599);
    chk("recycle p2x", int'(bus.pipe2_x), 199);
    chk("recycle p3x", int'(bus.pipe3_x), 399);
    chk("recycle p1y1", int'(bus.pipe1_y1), y_exp);
    chk("recycle p1y0", int'(bus.pipe1_y0), y_exp + 120);
    chk("recycle p2y1", int'(bus.pipe2_y1), 180);

    // Freeze and restart: gaps reload, lfsr keeps running.
    step(1, 0, 1);
    chk("over p1x", int'(bus.pipe1_x), 599);
    chk("over running", int'(bus.running), 0);
    step(0, 1, 0);
    chk("restart p1x", int'(bus.pipe1_x), 400);
    chk("restart p1y1", int'(bus.pipe1_y1), 180);
    chk("restart p1y0", int'(bus.pipe1_y0), 300);
    chk("restart running", int'(bus.running), 1);

    // Long run with random tick spacing, checked against the model every cycle.
    m_x[0] = 400; m_x[1] = 600; m_x[2] = 800;
    for (int k = 0; k < 3; k++) m_y1[k] = 180;
    for (int n = 0; n < 3000; n++) begin
      int idle;
      idle = int'($urandom_range(0, 2));
      for (int j = 0; j < idle; j++) begin
        step(0, 0, 0);
        check_model("idle");
      end
      step(1, 0, 0);
      model_tick(lf_pre);
      check_model("tick");
    end

    // Asynchronous reset between clock edges.
    #3 reset = 1'b0;
    #2 check_reset_values("midrun_reset");
    #1 reset = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0);
    chk("post_reset idle p1x", int'(bus.pipe1_x), 400);
    chk("post_reset running", int'(bus.running), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
